wasm_lsu: RTL

// Load/store unit: initiator side of the linear-memory read/write ports. Takes
// one memarg access per request from the execute stage and computes the

---
 rtl/wasm_lsu.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/wasm_lsu.sv
// wasm_lsu: load/store unit for the linear-memory read/write ports.
// Accepts one memarg access at a time, forms base+offset with a 33-bit carry
// check, issues a single read or write and returns one response.
// Optional feature: define LSU_STATS_EN to add saturating load/store/trap counters.

package wasm_pkg;
    typedef enum logic [3:0] {
        OP_NONE         = 4'd0,
        OP_I32_LOAD     = 4'd1,
        OP_I64_LOAD     = 4'd2,
        OP_I32_LOAD8_S  = 4'd3,
        OP_I32_LOAD8_U  = 4'd4,
        OP_I32_LOAD16_S = 4'd5,
        OP_I32_LOAD16_U = 4'd6,
        OP_I64_LOAD32_S = 4'd7,
        OP_I64_LOAD32_U = 4'd8,
        OP_I32_STORE    = 4'd9,
        OP_I64_STORE    = 4'd10,
        OP_I32_STORE8   = 4'd11,
        OP_I32_STORE16  = 4'd12,
        OP_I64_STORE32  = 4'd13
    } mem_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE          = 2'd0,
        TRAP_OUT_OF_BOUNDS = 2'd1
    } trap_t;
endpackage

module wasm_lsu
    import wasm_pkg::*;
#(
    parameter int STORE_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  mem_op_t     req_op,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [63:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output trap_t       resp_trap,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    output mem_op_t     mem_rd_op,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_valid,
    input  trap_t       mem_trap,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output mem_op_t     mem_wr_op,
    output logic [63:0] mem_wr_data,
    input  logic        mem_wr_valid
`ifdef LSU_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_traps
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WR, S_RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(STORE_WAIT - 1);

    state_t      state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [63:0] data_q, data_d;
    logic        is_store_q, is_store_d;
    logic [32:0] ea_q, ea_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [63:0] resp_data_q, resp_data_d;
    trap_t       resp_trap_q, resp_trap_d;

    // Memory returns raw little-endian bytes in the low bits; widen to the wasm value.
    function automatic logic [63:0] load_extend(input mem_op_t op, input logic [63:0] raw);
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] w32;
        logic signed [31:0] s32;
        logic signed [63:0] s64;
        b8  = raw[7:0];
        h16 = raw[15:0];
        w32 = raw[31:0];
        case (op)
            OP_I32_LOAD:     return {32'h0, raw[31:0]};
            OP_I64_LOAD:     return raw;
            OP_I32_LOAD8_S:  begin s32 = b8;  return {32'h0, s32}; end
            OP_I32_LOAD8_U:  return {56'h0, raw[7:0]};
            OP_I32_LOAD16_S: begin s32 = h16; return {32'h0, s32}; end
            OP_I32_LOAD16_U: return {48'h0, raw[15:0]};
            OP_I64_LOAD32_S: begin s64 = w32; return s64; end
            OP_I64_LOAD32_U: return {32'h0, raw[31:0]};
            default:         return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

`ifdef LSU_STATS_EN
    logic [31:0] loads_q, loads_d, stores_q, stores_d, traps_q, traps_d;
    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_traps  = traps_q;
`endif

    assign resp_data = resp_data_q;
    assign resp_trap = resp_trap_q;

    // Next-state, capture and memory-port drive for the access sequence.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        is_store_d  = is_store_q;
        ea_d        = ea_q;
        wcnt_d      = wcnt_q;
        resp_data_d = resp_data_q;
        resp_trap_d = resp_trap_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = 32'h0;
        mem_rd_op   = OP_NONE;
        mem_wr_en   = 1'b0;
        mem_wr_addr = 32'h0;
        mem_wr_op   = OP_NONE;
        mem_wr_data = 64'h0;
`ifdef LSU_STATS_EN
        loads_d  = loads_q;
        stores_d = stores_q;
        traps_d  = traps_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d       = req_op;
                    data_d     = req_data;
                    is_store_d = req_is_store;
                    ea_d       = {1'b0, req_base} + {1'b0, req_offset};
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ea_q[32]) begin
                    // Carry out of the 32-bit address space: never touch memory.
                    resp_data_d = 64'h0;
                    resp_trap_d = TRAP_OUT_OF_BOUNDS;
                    state_d     = S_RESP;
                end else if (is_store_q) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = ea_q[31:0];
                    mem_wr_op   = op_q;
                    mem_wr_data = data_q;
                    wcnt_d      = 8'h0;
                    state_d     = S_WAIT_WR;
                end else begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = ea_q[31:0];
                    mem_rd_op   = op_q;
                    if (mem_rd_valid) begin
                        resp_data_d = load_extend(op_q, mem_rd_data);
                        resp_trap_d = TRAP_NONE;
                    end else begin
                        resp_data_d = 64'h0;
                        resp_trap_d = (mem_trap != TRAP_NONE) ? mem_trap : TRAP_OUT_OF_BOUNDS;
                    end
                    state_d = S_RESP;
                end
            end
            S_WAIT_WR: begin
                if (wcnt_q == WAIT_LAST) begin
                    resp_data_d = 64'h0;
                    resp_trap_d = mem_wr_valid ? TRAP_NONE : TRAP_OUT_OF_BOUNDS;
                    state_d     = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_data_d = 64'h0;
                    resp_trap_d = TRAP_NONE;
                    state_d     = S_IDLE;
`ifdef LSU_STATS_EN
                    if (resp_trap_q != TRAP_NONE) traps_d  = sat_inc(traps_q);
                    else if (is_store_q)          stores_d = sat_inc(stores_q);
                    else                          loads_d  = sat_inc(loads_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 8'h0;
            resp_data_q <= 64'h0;
            resp_trap_q <= TRAP_NONE;
`ifdef LSU_STATS_EN
            loads_q     <= 32'h0;
            stores_q    <= 32'h0;
            traps_q     <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            resp_data_q <= resp_data_d;
            resp_trap_q <= resp_trap_d;
`ifdef LSU_STATS_EN
            loads_q     <= loads_d;
            stores_q    <= stores_d;
            traps_q     <= traps_d;
`endif
        end
    end

    // Request operands; only consumed while an access is in flight.
    always_ff @(posedge clk) begin
        op_q       <= op_d;
        data_q     <= data_d;
        is_store_q <= is_store_d;
        ea_q       <= ea_d;
    end

endmodule
